// File: rtl/alu_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the decoder/ALU side and the
// multi-byte ADD/SUB/CMP sequencer.
interface alu_seq_ctrl_if #(
    parameter int IDX_W = 3,
    parameter int LEN_W = IDX_W + 1
);
    logic             start;
    logic [1:0]       op;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] byte_idx;
    logic             alu_csel;
    logic             alu_sub_sel;
    logic             alu_cclear;
    logic             alu_eop;
    logic [7:0]       alu_s;
    logic             alu_sign_reg;
    logic             res_we;
    logic [IDX_W-1:0] res_idx;
    logic [7:0]       res_data;
    logic             zero;
    logic             sign;

    modport master (
        output start, op, len, alu_s, alu_sign_reg,
        input  busy, done, byte_idx, alu_csel, alu_sub_sel, alu_cclear,
               alu_eop, res_we, res_idx, res_data, zero, sign
    );

    modport slave (
        input  start, op, len, alu_s, alu_sign_reg,
        output busy, done, byte_idx, alu_csel, alu_sub_sel, alu_cclear,
               alu_eop, res_we, res_idx, res_data, zero, sign
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Byte-serial sequencer for multi-byte ADD/SUB/CMP on the 8-bit CLA datapath:
// walks operand bytes LSB first, chains carry, writes results, reports flags.
module alu_seq_ctrl #(
    parameter int MAX_BYTES = 8,
    parameter int IDX_W     = $clog2(MAX_BYTES),
    parameter int LEN_W     = IDX_W + 1
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_e;

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;

    state_e           state_q;
    logic [1:0]       op_q;
    logic [LEN_W-1:0] len_q;
    logic [IDX_W-1:0] idx_q;
    logic             zacc_q;
    logic             zero_q;
    logic             sign_q;
    logic             busy_q;
    logic             done_q;
    logic             csel_q;
    logic             subSel_q;
    logic             cclear_q;
    logic             eop_q;
    logic             resWe_q;

    logic [LEN_W-1:0] lenEff;
    logic             isSub;
    logic             isCmp;
    logic             lastByte;
    logic             zacc_d;

    assign lenEff   = (bus.len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : bus.len;
    assign isSub    = (op_q == OP_SUB) || (op_q == OP_CMP);
    assign isCmp    = (op_q == OP_CMP);
    assign lastByte = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));
    assign zacc_d   = zacc_q & (bus.alu_s == 8'h00);

    // Control outputs are registered on entry to EXEC so they are stable for the whole byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            zacc_q   <= 1'b1;
            zero_q   <= 1'b1;
            sign_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            csel_q   <= 1'b0;
            subSel_q <= 1'b0;
            cclear_q <= 1'b0;
            eop_q    <= 1'b0;
            resWe_q  <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            csel_q   <= 1'b0;
            subSel_q <= 1'b0;
            cclear_q <= 1'b0;
            eop_q    <= 1'b0;
            resWe_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        len_q  <= lenEff;
                        idx_q  <= '0;
                        zacc_q <= 1'b1;
                        if (lenEff == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            zero_q  <= 1'b1;
                            sign_q  <= 1'b0;
                        end else begin
                            state_q <= FETCH;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    state_q  <= EXEC;
                    cclear_q <= 1'b1;
                    csel_q   <= (idx_q != '0);
                    subSel_q <= isSub;
                    eop_q    <= lastByte;
                    resWe_q  <= !isCmp;
                end
                EXEC: begin
                    zacc_q <= zacc_d;
                    if (lastByte) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        zero_q  <= zacc_d;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        state_q <= FETCH;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    if (len_q != '0) sign_q <= bus.alu_sign_reg;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The ALU latches its sign at the edge ending the last EXEC, so DONE shows it directly.
    assign bus.sign        = (state_q == DONE && len_q != '0) ? bus.alu_sign_reg : sign_q;
    assign bus.zero        = zero_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.byte_idx    = idx_q;
    assign bus.alu_csel    = csel_q;
    assign bus.alu_sub_sel = subSel_q;
    assign bus.alu_cclear  = cclear_q;
    assign bus.alu_eop     = eop_q;
    assign bus.res_we      = resWe_q;
    assign bus.res_idx     = idx_q;
    assign bus.res_data    = bus.alu_s;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a behavioural byte ALU and RAMs around the sequencer,
// with results compared against whole-word arithmetic on the operands.
module tb_alu_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   testsRun  = 0;
    int   failCount = 0;
    int   writeCount = 0;
    bit   prevZero = 1'b1;
    bit   prevSign = 1'b0;

    logic [7:0] memA [8];
    logic [7:0] memB [8];
    logic [7:0] resMem [8];
    logic [7:0] aRd, bRd;
    logic       carryReg, signReg, cin, carryOut;
    logic [8:0] sumFull;

    alu_seq_ctrl_if bus ();

    alu_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign cin          = bus.alu_csel ? carryReg : bus.alu_sub_sel;
    assign sumFull      = {1'b0, aRd} + {1'b0, (bus.alu_sub_sel ? ~bRd : bRd)} + {8'b0, cin};
    assign carryOut     = sumFull[8];
    assign bus.alu_s    = sumFull[7:0];
    assign bus.alu_sign_reg = signReg;

    always @(posedge clk) begin
        aRd <= memA[bus.byte_idx];
        bRd <= memB[bus.byte_idx];
        if (bus.alu_cclear) carryReg <= carryOut;
        if (bus.alu_cclear && bus.alu_eop) signReg <= bus.alu_s[7];
        if (bus.res_we) begin
            resMem[bus.res_idx] <= bus.res_data;
            writeCount <= writeCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One operation from start to the idle cycle after done; optional mid-op start poke or reset.
    task automatic applyStimulus(input logic [1:0] opIn, input int lenIn,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input bit pokeStart, input bit resetMid);
        int          lenEff;
        int          cyc;
        int          base;
        bit          sub;
        bit          expZero, expSign;
        logic [63:0] mask, expRes;
        lenEff = (lenIn > 8) ? 8 : lenIn;
        sub    = (opIn == 2'd1) || (opIn == 2'd2);
        mask   = (lenEff == 8) ? '1 : ((64'd1 << (8 * lenEff)) - 64'd1);
        expRes = (sub ? (a - b) : (a + b)) & mask;
        expZero = (expRes == 64'd0);
        expSign = (lenEff > 0) ? expRes[8 * lenEff - 1] : 1'b0;
        for (int i = 0; i < 8; i++) begin
            memA[i] = a[8 * i +: 8];
            memB[i] = b[8 * i +: 8];
        end
        base      = writeCount;
        bus.op    = opIn;
        bus.len   = 4'(lenIn);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.len   = 4'($urandom);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc <= 40) begin
            if (cyc == 1) begin
                checkOutput("heldZero", 64'(bus.zero), 64'(prevZero));
                checkOutput("heldSign", 64'(bus.sign), 64'(prevSign));
            end
            checkOutput("busy", 64'(bus.busy), 64'd1);
            if (cyc % 2 == 1) begin
                checkOutput("fetchIdx", 64'(bus.byte_idx), 64'((cyc - 1) / 2));
                checkOutput("fetchWe", 64'(bus.res_we), 64'd0);
                checkOutput("fetchCclear", 64'(bus.alu_cclear), 64'd0);
            end else begin
                checkOutput("execIdx", 64'(bus.byte_idx), 64'(cyc / 2 - 1));
                checkOutput("execCclear", 64'(bus.alu_cclear), 64'd1);
                checkOutput("execCsel", 64'(bus.alu_csel), 64'(cyc > 2));
                checkOutput("execEop", 64'(bus.alu_eop), 64'(cyc == 2 * lenEff));
                checkOutput("execSubSel", 64'(bus.alu_sub_sel), 64'(sub));
                checkOutput("execWe", 64'(bus.res_we), 64'(opIn != 2'd2));
            end
            if (pokeStart && cyc == 3) bus.start = 1'b1;
            if (pokeStart && cyc == 4) bus.start = 1'b0;
            if (resetMid && cyc == 4) begin
                rst = 1'b1;
                @(negedge clk);
                checkOutput("rstBusy", 64'(bus.busy), 64'd0);
                checkOutput("rstWe", 64'(bus.res_we), 64'd0);
                checkOutput("rstZero", 64'(bus.zero), 64'd1);
                checkOutput("rstIdx", 64'(bus.byte_idx), 64'd0);
                rst = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    checkOutput("postRstDone", 64'(bus.done), 64'd0);
                    checkOutput("postRstWe", 64'(bus.res_we), 64'd0);
                end
                checkOutput("rstWrites", 64'(writeCount - base), 64'd2);
                prevZero = 1'b1;
                prevSign = 1'b0;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput("doneCycle", 64'(cyc), 64'(2 * lenEff + 1));
        checkOutput("doneBusy", 64'(bus.busy), 64'd0);
        checkOutput("zero", 64'(bus.zero), 64'(expZero));
        checkOutput("sign", 64'(bus.sign), 64'(expSign));
        checkOutput("writes", 64'(writeCount - base), 64'((opIn == 2'd2) ? 0 : lenEff));
        if (opIn != 2'd2) begin
            for (int i = 0; i < lenEff; i++)
                checkOutput("resByte", 64'(resMem[i]), 64'(expRes[8 * i +: 8]));
        end
        @(negedge clk);
        checkOutput("idleDone", 64'(bus.done), 64'd0);
        checkOutput("holdZero", 64'(bus.zero), 64'(expZero));
        checkOutput("holdSign", 64'(bus.sign), 64'(expSign));
        prevZero = expZero;
        prevSign = expSign;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op = 2'd0;
        bus.len = '0;
        for (int i = 0; i < 8; i++) begin
            memA[i] = 8'h00;
            memB[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        checkOutput("resetBusy", 64'(bus.busy), 64'd0);
        checkOutput("resetDone", 64'(bus.done), 64'd0);
        checkOutput("resetWe", 64'(bus.res_we), 64'd0);
        checkOutput("resetIdx", 64'(bus.byte_idx), 64'd0);
        checkOutput("resetCsel", 64'(bus.alu_csel), 64'd0);
        checkOutput("resetSubSel", 64'(bus.alu_sub_sel), 64'd0);
        checkOutput("resetCclear", 64'(bus.alu_cclear), 64'd0);
        checkOutput("resetEop", 64'(bus.alu_eop), 64'd0);
        checkOutput("resetZero", 64'(bus.zero), 64'd1);
        checkOutput("resetSign", 64'(bus.sign), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(2'd0, 2, 64'h01FF, 64'h0001, 1'b0, 1'b0);
        applyStimulus(2'd1, 2, 64'h0100, 64'h0001, 1'b0, 1'b0);
        applyStimulus(2'd2, 3, 64'h123456, 64'h123456, 1'b0, 1'b0);
        applyStimulus(2'd0, 0, 64'h55, 64'h66, 1'b0, 1'b0);
        applyStimulus(2'd0, 12, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
        applyStimulus(2'd1, 1, 64'h00, 64'h01, 1'b0, 1'b0);
        applyStimulus(2'd3, 3, 64'h80FFFF, 64'h000001, 1'b0, 1'b0);
        applyStimulus(2'd0, 3, 64'h123, 64'h456, 1'b1, 1'b0);
        applyStimulus(2'd0, 4, 64'h11223344, 64'h01010101, 1'b0, 1'b1);
        applyStimulus(2'd2, 8, 64'h7, 64'h9, 1'b0, 1'b0);
        for (int n = 0; n < 20; n++) begin
            applyStimulus(2'($urandom), int'($urandom_range(0, 12)),
                          {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
